// File: rtl/kernel_host_pkg.sv
// Shared types and default widths for the kernel array host and its storage.
package kernel_host_pkg;

    localparam int unsigned ADDR_W_DEF   = 1;
    localparam int unsigned DATA_W_DEF   = 1;
    localparam int unsigned RESULT_W_DEF = 2;
    localparam int unsigned TIMEOUT_DEF  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/kernel_array_ram.sv
// Array storage with async clear, one write port and one registered read port
// shared between the host and the kernel; each side keeps its own read register.
module kernel_array_ram
    import kernel_host_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_sel,
    input  logic              kern_sel,
    input  logic              host_we,
    input  logic              host_re,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              kern_we,
    input  logic [ADDR_W-1:0] kern_addr,
    input  logic [DATA_W-1:0] kern_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic [DATA_W-1:0] kern_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0] kern_rdata_q, kern_rdata_d;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    // Port owner mux: the kernel owns the array only while it runs.
    always_comb begin
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (kern_sel) begin
            we    = kern_we;
            addr  = kern_addr;
            wdata = kern_wdata;
        end else if (host_sel) begin
            we    = host_we;
            addr  = host_addr;
            wdata = host_wdata;
        end
    end

    // Reads sample mem_q, so a same-cycle write to the same word returns old data.
    always_comb begin
        mem_d        = mem_q;
        host_rdata_d = host_rdata_q;
        kern_rdata_d = kern_rdata_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
        if (kern_sel) begin
            kern_rdata_d = mem_q[addr];
        end
        if (host_sel && host_re) begin
            host_rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            host_rdata_q <= '0;
            kern_rdata_q <= '0;
        end else begin
            mem_q        <= mem_d;
            host_rdata_q <= host_rdata_d;
            kern_rdata_q <= kern_rdata_d;
        end
    end

    assign host_rdata = host_rdata_q;
    assign kern_rdata = kern_rdata_q;

endmodule

// File: rtl/kernel_array_host.sv
// Host-side responder for one kernel: owns its array, issues the start pulse,
// captures the result on the done edge and forces completion after TIMEOUT cycles.
module kernel_array_host
    import kernel_host_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RESULT_W = RESULT_W_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                host_wr_en,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic                host_rd_en,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                host_ack,
    input  logic                host_start,
    output logic                host_busy,
    output logic                host_done,
    output logic                host_timeout,
    output logic [RESULT_W-1:0] host_result,
    output logic                kern_r_enable,
    input  logic                kern_w_enable,
    input  logic [RESULT_W-1:0] kern_result,
    input  logic                arr_wenable,
    input  logic [ADDR_W-1:0]   arr_addr,
    input  logic [DATA_W-1:0]   arr_wdata,
    output logic [DATA_W-1:0]   arr_rdata
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                prev_q, prev_d;
    logic [RESULT_W-1:0] host_result_q, host_result_d;
    logic                host_timeout_q, host_timeout_d;
    logic                host_done_q, host_done_d;
    logic                host_ack_q, host_ack_d;
    logic                kern_r_enable_q, kern_r_enable_d;
    logic                host_busy_q, host_busy_d;
    logic                host_live;
    logic                kern_live;

    assign host_live = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign kern_live = (state_q == ST_RUN);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        prev_d         = kern_w_enable;
        host_result_d  = host_result_q;
        host_timeout_d = host_timeout_q;
        host_done_d    = 1'b0;
        host_ack_d     = host_live && (host_wr_en || host_rd_en);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (host_start) begin
                    state_d        = ST_START;
                    cnt_d          = '0;
                    host_timeout_d = 1'b0;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Only a fresh rising edge counts; a level left over from a prior run does not.
                if (kern_w_enable && !prev_q) begin
                    host_result_d = kern_result;
                    host_done_d   = 1'b1;
                    state_d       = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    host_timeout_d = 1'b1;
                    host_done_d    = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        kern_r_enable_d = (state_d == ST_START);
        host_busy_d     = (state_d == ST_START) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            prev_q          <= 1'b0;
            host_result_q   <= '0;
            host_timeout_q  <= 1'b0;
            host_done_q     <= 1'b0;
            host_ack_q      <= 1'b0;
            kern_r_enable_q <= 1'b0;
            host_busy_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            prev_q          <= prev_d;
            host_result_q   <= host_result_d;
            host_timeout_q  <= host_timeout_d;
            host_done_q     <= host_done_d;
            host_ack_q      <= host_ack_d;
            kern_r_enable_q <= kern_r_enable_d;
            host_busy_q     <= host_busy_d;
        end
    end

    kernel_array_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .host_sel   (host_live),
        .kern_sel   (kern_live),
        .host_we    (host_wr_en),
        .host_re    (host_rd_en),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .kern_we    (arr_wenable),
        .kern_addr  (arr_addr),
        .kern_wdata (arr_wdata),
        .host_rdata (host_rdata),
        .kern_rdata (arr_rdata)
    );

    assign host_ack      = host_ack_q;
    assign host_busy     = host_busy_q;
    assign host_done     = host_done_q;
    assign host_timeout  = host_timeout_q;
    assign host_result   = host_result_q;
    assign kern_r_enable = kern_r_enable_q;

endmodule

// File: doc/kernel_array_host.md
Name: kernel_array_host

Overview:
- Host-side responder for a synthesized kernel's start/done handshake (r_enable / w_enable / result) and its single-port array interface (WEnable / Addr / WData out of the kernel, RData back into it).
- Owns the array storage, serves kernel array accesses with fixed 1-cycle read latency, and issues the kernel start pulse.
- Captures the kernel result on completion and enforces a watchdog timeout.
- Sits between a testbench or host controller and one kernel instance.

Parameters:
- ADDR_W, 1, array address width; DEPTH = 2**ADDR_W.
- DATA_W, 1, array element width.
- RESULT_W, 2, kernel result width.
- TIMEOUT, 1024, maximum RUN cycles before forced completion; must be ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- host_wr_en  in  1  host array write request.
- host_addr  in  ADDR_W  host array address, used for both write and read.
- host_wdata  in  DATA_W  host write data.
- host_rd_en  in  1  host array read request.
- host_rdata  out  DATA_W  host read data, valid 1 cycle after host_rd_en.
- host_ack  out  1  pulses 1 cycle after an accepted host read or write.
- host_start  in  1  start request.
- host_busy  out  1  high in START or RUN.
- host_done  out  1  one-cycle completion pulse.
- host_timeout  out  1  sticky; set when the last run timed out.
- host_result  out  RESULT_W  captured kernel result.
- kern_r_enable  out  1  kernel start pulse.
- kern_w_enable  in  1  kernel done level.
- kern_result  in  RESULT_W  kernel result.
- arr_wenable  in  1  kernel array write enable.
- arr_addr  in  ADDR_W  kernel array address.
- arr_wdata  in  DATA_W  kernel write data.
- arr_rdata  out  DATA_W  kernel read data, registered.

Behaviour:
- Reset: one clock domain; rst is asynchronous and active-high. All outputs 0, state IDLE, all DEPTH array words cleared to 0, cycle counter 0, done-edge register 0.
- States: IDLE, START, RUN, DONE.
- IDLE/DONE:
  - Host port is live.
  - host_wr_en writes mem[host_addr] at the clock edge.
  - host_rd_en loads host_rdata from mem[host_addr] at the clock edge.
  - If both host_wr_en and host_rd_en are high, the write is performed and host_rdata returns the old data.
  - host_ack = 1 on the following cycle.
  - Kernel array writes are ignored.
- host_start in IDLE/DONE: go to START.
  - Clear host_timeout and the counter.
  - Load the done-edge register with the current kern_w_enable.
  - A host write in the same cycle as host_start is still performed.
- START: kern_r_enable = 1 for exactly one cycle, then RUN.
- RUN:
  - Host reads and writes are ignored; host_ack stays 0.
  - arr_wenable writes mem[arr_addr] = arr_wdata.
  - arr_rdata <= mem[arr_addr] every cycle, read-before-write: the same-address write in the same cycle returns the old value.
  - Counter increments each cycle.
  - Completion is a rising edge of kern_w_enable (current 1, previous 0). On completion: host_result <= kern_result, host_done pulses on the next cycle, go to DONE.
  - A kern_w_enable already high on entry to RUN (stale level from a previous run) is not a completion.
  - Timeout: if the counter reaches TIMEOUT-1 without completion, set host_timeout, leave host_result unchanged, pulse host_done, go to DONE.
  - If completion and timeout occur in the same cycle, completion wins and host_timeout stays 0.
- arr_rdata holds its last value outside RUN.
- host_busy = (state == START || state == RUN).
- host_start while busy is ignored.
- Reset mid-run: immediate return to IDLE, memory cleared, kern_r_enable 0, no host_done pulse.
- Addresses always lie in range because DEPTH = 2**ADDR_W; no wrap logic is needed.
- Counter width is clog2(TIMEOUT); the counter saturates and never wraps.

Decomposition:
- Shared package kernel_host_pkg holds:
  - state enum (IDLE, START, RUN, DONE);
  - default widths;
  - TIMEOUT default.
- One sub-module, kernel_array_ram:
  - DEPTH x DATA_W storage, async clear;
  - one registered read port and one write port;
  - host/kernel mux selected by the top-level state.

Test Plan:
1. Assert rst with clk running, release → all outputs 0; host read of addr 0 and addr 1 → host_rdata 0, host_ack pulse each time.
2. Host writes mem[1]=1, then pulses host_start → kern_r_enable high exactly 1 cycle, 1 cycle after start; kernel model drives arr_addr=1 → arr_rdata=1 next cycle.
3. Kernel model raises kern_w_enable with kern_result=2 on RUN cycle 5 → host_result=2, host_done 1-cycle pulse, host_busy 0, host_timeout 0; repeat with mem[1]=0 and kern_result=3 → host_result=3.
4. In RUN, host_wr_en to addr 0 with data 1 and kernel arr_wenable to addr 1 with data 0 → host_ack 0, mem[0] unchanged, mem[1]=0; same-cycle kernel read of addr 1 returns the old value 1.
5. TIMEOUT=16, kernel never responds → host_done exactly 16 cycles after entering RUN, host_timeout=1, host_result unchanged; next host_start clears host_timeout.
6. kern_w_enable held high across a restart → no completion until it falls and rises again; rst asserted mid-RUN → IDLE, kern_r_enable 0, memory reads 0, no host_done.
